// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - FSM state type and QoS priority-key helpers for stream_arbiter_qos
package stream_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Widest QoS field the key helpers accept; callers cast down to QOS_WIDTH+1.
  localparam int unsigned QOS_WIDTH_MAX = 16;
  localparam int unsigned KEY_WIDTH_MAX = QOS_WIDTH_MAX + 1;

  // Key that outranks every non-zero QoS value of the given width.
  function automatic logic [KEY_WIDTH_MAX-1:0] urgent_key(input int unsigned qos_width);
    return KEY_WIDTH_MAX'(1) << qos_width;
  endfunction

  // QoS 0 means urgent; any other QoS ranks by its plain value.
  function automatic logic [KEY_WIDTH_MAX-1:0] qos_key(
    input logic [QOS_WIDTH_MAX-1:0] qos,
    input int unsigned              qos_width
  );
    logic [KEY_WIDTH_MAX-1:0] key;
    if (qos == '0) begin
      key = urgent_key(qos_width);
    end else begin
      key = {1'b0, qos};
    end
    return key;
  endfunction

endpackage

// File: rtl/qos_rr_picker.sv
// rtl/qos_rr_picker.sv - combinational max-key picker with round-robin tie break
module qos_rr_picker #(
  parameter int STREAM_COUNT = 4,
  parameter int KEY_WIDTH    = 5,
  parameter int ID_WIDTH     = 2
) (
  input  logic [STREAM_COUNT-1:0]                valid,
  input  logic [STREAM_COUNT-1:0][KEY_WIDTH-1:0] key,
  input  logic [ID_WIDTH-1:0]                    rr_ptr,
  output logic [ID_WIDTH-1:0]                    pick_id
);

  // Scan starting one past rr_ptr; a strict compare keeps the earliest equal key in scan order.
  always_comb begin
    logic                 found;
    logic [KEY_WIDTH-1:0] best_key;
    int                   idx;
    found    = 1'b0;
    best_key = '0;
    pick_id  = '0;
    idx      = 0;
    for (int k = 1; k <= STREAM_COUNT; k++) begin
      idx = (int'(rr_ptr) + k) % STREAM_COUNT;
      if (valid[idx] && (!found || (key[idx] > best_key))) begin
        found    = 1'b1;
        best_key = key[idx];
        pick_id  = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_qos.sv
// rtl/stream_arbiter_qos.sv - packet-level QoS stream arbiter, optional aging via STREAM_ARB_AGING_EN
module stream_arbiter_qos
  import stream_arb_pkg::*;
#(
  parameter int STREAM_COUNT = 4,
  parameter int QOS_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = $clog2(STREAM_COUNT),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [STREAM_COUNT-1:0][DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][QOS_WIDTH-1:0]  s_qos_i,
  input  logic [STREAM_COUNT-1:0]                 s_last_i,
  input  logic [STREAM_COUNT-1:0]                 s_valid_i,
  output logic [STREAM_COUNT-1:0]                 s_ready_o,
  output logic [DATA_WIDTH-1:0]                   m_data_o,
  output logic [ID_WIDTH-1:0]                     m_id_o,
  output logic [QOS_WIDTH-1:0]                    m_qos_o,
  output logic                                    m_last_o,
  output logic                                    m_valid_o,
  input  logic                                    m_ready_i
);

  localparam int KEY_WIDTH = QOS_WIDTH + 1;

  arb_state_e                             state_q;
  arb_state_e                             state_d;
  logic [ID_WIDTH-1:0]                    grant_id;
  logic [ID_WIDTH-1:0]                    rr_ptr;
  logic [ID_WIDTH-1:0]                    pick_id;
  logic [QOS_WIDTH-1:0]                   qos_q;
  logic [STREAM_COUNT-1:0][KEY_WIDTH-1:0] key;
  logic                                   arb_go;
  logic                                   pkt_done;

  // An arbitration happens in IDLE whenever any stream is offering data.
  assign arb_go   = (state_q == ARB_IDLE) && (|s_valid_i);
  // Final beat of the granted packet is accepted downstream this cycle.
  assign pkt_done = (state_q == ARB_BUSY) && s_valid_i[grant_id] && m_ready_i && s_last_i[grant_id];

  assign m_qos_o = qos_q;

`ifdef STREAM_ARB_AGING_EN
  localparam int                   CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_LIMIT);

  logic [STREAM_COUNT-1:0][CNT_WIDTH-1:0] age_cnt;

  // Starved streams are promoted to the urgent key; others rank by QoS.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (age_cnt[i] == CNT_MAX) begin
        key[i] = KEY_WIDTH'(urgent_key(QOS_WIDTH));
      end else begin
        key[i] = KEY_WIDTH'(qos_key(QOS_WIDTH_MAX'(s_qos_i[i]), QOS_WIDTH));
      end
    end
  end

  // Losers of an arbitration age (saturating); the winner starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cnt <= '0;
    end else if (arb_go) begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        if (ID_WIDTH'(i) == pick_id) begin
          age_cnt[i] <= '0;
        end else if (s_valid_i[i] && (age_cnt[i] != CNT_MAX)) begin
          age_cnt[i] <= age_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;

  // Without aging the key is a pure function of the stream's QoS.
  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      key[i] = KEY_WIDTH'(qos_key(QOS_WIDTH_MAX'(s_qos_i[i]), QOS_WIDTH));
    end
  end
`endif

  qos_rr_picker #(
    .STREAM_COUNT (STREAM_COUNT),
    .KEY_WIDTH    (KEY_WIDTH),
    .ID_WIDTH     (ID_WIDTH)
  ) u_picker (
    .valid   (s_valid_i),
    .key     (key),
    .rr_ptr  (rr_ptr),
    .pick_id (pick_id)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, QoS snapshot and round-robin pointer; rr_ptr starts at the last stream so stream 0 wins first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr   <= ID_WIDTH'(STREAM_COUNT - 1);
      qos_q    <= '0;
    end else begin
      if (arb_go) begin
        grant_id <= pick_id;
        qos_q    <= s_qos_i[pick_id];
      end
      if (pkt_done) begin
        rr_ptr <= grant_id;
      end
    end
  end

  // Next state and the combinational stream mux; everything reads 0 while idle.
  always_comb begin
    state_d   = state_q;
    s_ready_o = '0;
    m_data_o  = '0;
    m_id_o    = '0;
    m_last_o  = 1'b0;
    m_valid_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_go) begin
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_data_o            = s_data_i[grant_id];
        m_last_o            = s_last_i[grant_id];
        m_valid_o           = s_valid_i[grant_id];
        m_id_o              = grant_id;
        s_ready_o[grant_id] = m_ready_i;
        if (pkt_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule
